// File: rtl/calc_display_pkg.sv
// -----------------------------------------------------------------------------
// calc_display_pkg
// Shared definitions for the display text buffer writer:
//   - default geometry (vector width, operand width, BCD digit count, cursor)
//   - symbol codes understood by the text renderer
//   - command opcode and writer FSM state encodings
//   - derivation of the cell count from the vector width
// -----------------------------------------------------------------------------
package calc_display_pkg;

  // Default geometry: 384-bit vector of 4-bit cells, 16-bit operands.
  localparam int MAX_INPUT_DEF = 384;
  localparam int NUM_W_DEF     = 16;
  localparam int DIGITS_DEF    = 5;

  // One cell is one 4-bit symbol code.
  function automatic int cells_of(input int max_input);
    return max_input / 4;
  endfunction

  localparam int CELLS_DEF = cells_of(MAX_INPUT_DEF);
  // Cursor must be able to hold CELLS itself (the "full" position).
  localparam int CUR_W_DEF = $clog2(CELLS_DEF + 1);

  // Symbol codes; 0-9 are the decimal digits themselves.
  localparam logic [3:0] SYM_PLUS  = 4'hA;
  localparam logic [3:0] SYM_MINUS = 4'hB;
  localparam logic [3:0] SYM_MUL   = 4'hC;
  localparam logic [3:0] SYM_DIV   = 4'hD;
  localparam logic [3:0] SYM_EQ    = 4'hE;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  typedef enum logic [1:0] {
    OP_PUTSYM    = 2'b00,
    OP_BACKSPACE = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_PUTNUM    = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_CONV  = 2'b10,
    ST_EMIT  = 2'b11
  } wr_state_e;

endpackage

// File: rtl/bin2bcd_serial.sv
// -----------------------------------------------------------------------------
// bin2bcd_serial
// Sequential binary to BCD converter (double dabble), one input bit per cycle.
// A start pulse while idle latches bin; NUM_W shift-add-3 steps follow, the
// last of which also latches the result into bcd and pulses done.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a conversion (ignored while busy)
//   bin       : unsigned operand, sampled with start
//   busy      : conversion in progress
//   done      : one-cycle pulse, bcd valid from this cycle on
//   bcd       : DIGITS packed BCD digits, least significant in [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_serial
  import calc_display_pkg::*;
#(
  parameter int NUM_W  = NUM_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] acc_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] shifted;

  // Add 3 to every digit that would overflow past 9 once doubled.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ?
                              (acc_q[4*gi +: 4] + 4'd3) : acc_q[4*gi +: 4];
    end
  endgenerate

  // Shift the next binary bit (MSB first) into the BCD accumulator. The top
  // adjusted bit is always zero because DIGITS covers the operand range.
  assign shifted = (4*DIGITS)'({adj, bin_q[NUM_W-1]});

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      acc_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        bin_q  <= bin;
        acc_q  <= '0;
        cnt_q  <= CNT_W'(NUM_W);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        acc_q <= shifted;
        bin_q <= {bin_q[NUM_W-2:0], 1'b0};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          bcd_q  <= shifted;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/calc_text_writer.sv
// -----------------------------------------------------------------------------
// calc_text_writer
// Writer side of the display text buffer. Owns the packed symbol vector read
// by the VGA text renderer and edits it from a command stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (all cells -> blank)
//   cmd_valid  : command present
//   cmd_ready  : writer idle, command accepted when cmd_valid && cmd_ready
//   cmd_op     : 00 PUTSYM, 01 BACKSPACE, 10 CLEAR, 11 PUTNUM
//   cmd_sym    : symbol code for PUTSYM
//   cmd_num    : unsigned operand for PUTNUM (printed in decimal)
//   numbers    : packed cells, cell i in numbers[4i+3:4i]
//   cursor     : next cell to be written, 0..CELLS
//   full       : cursor == CELLS
//   empty      : cursor == 0
//   cmd_err    : one-cycle pulse when a command is rejected
// -----------------------------------------------------------------------------
module calc_text_writer
  import calc_display_pkg::*;
#(
  parameter int MAX_INPUT = MAX_INPUT_DEF,
  parameter int NUM_W     = NUM_W_DEF,
  parameter int DIGITS    = DIGITS_DEF,
  parameter int CUR_W     = CUR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [3:0]           cmd_sym,
  input  logic [NUM_W-1:0]     cmd_num,
  output logic [MAX_INPUT-1:0] numbers,
  output logic [CUR_W-1:0]     cursor,
  output logic                 full,
  output logic                 empty,
  output logic                 cmd_err
);

  localparam int CELLS = cells_of(MAX_INPUT);
  localparam int SN_W  = $clog2(DIGITS + 1);

  wr_state_e           state_q, state_d;
  logic [CUR_W-1:0]    cursor_q, cursor_d;
  logic                cmd_err_q, cmd_err_d;
  // Digits still to emit, most significant aligned to the top nibble.
  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic [SN_W-1:0]     left_q, left_d;
  logic [3:0]          cell_q [CELLS];

  // Single cell write port shared by all commands.
  logic                wr_en;
  logic [CUR_W-1:0]    wr_idx;
  logic [3:0]          wr_val;

  logic                accept;
  logic                full_w, empty_w;
  logic [CUR_W-1:0]    free_cells;
  logic [SN_W-1:0]     sig_n;

  logic                b2b_start;
  logic                b2b_busy;
  logic                b2b_done;
  logic [4*DIGITS-1:0] b2b_bcd;

  bin2bcd_serial #(
    .NUM_W  (NUM_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (b2b_start),
    .bin   (cmd_num),
    .busy  (b2b_busy),
    .done  (b2b_done),
    .bcd   (b2b_bcd)
  );

  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign full_w     = (cursor_q == CUR_W'(CELLS));
  assign empty_w    = (cursor_q == '0);
  assign free_cells = CUR_W'(CELLS) - cursor_q;

  // Number of significant decimal digits; zero still prints one "0".
  always_comb begin
    sig_n = SN_W'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (b2b_bcd[4*i +: 4] != 4'd0) begin
        sig_n = SN_W'(i + 1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    cmd_err_d = 1'b0;
    digits_d  = digits_q;
    left_d    = left_q;
    wr_en     = 1'b0;
    wr_idx    = cursor_q;
    wr_val    = SYM_BLANK;
    b2b_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUTSYM: begin
              if (full_w) begin
                cmd_err_d = 1'b1;
              end else begin
                wr_en    = 1'b1;
                wr_val   = cmd_sym;
                cursor_d = cursor_q + 1'b1;
              end
            end
            OP_BACKSPACE: begin
              if (empty_w) begin
                cmd_err_d = 1'b1;
              end else begin
                wr_en    = 1'b1;
                wr_idx   = cursor_q - 1'b1;
                cursor_d = cursor_q - 1'b1;
              end
            end
            OP_CLEAR: begin
              // Clearing an empty line is a silent no-op.
              if (!empty_w) begin
                state_d = ST_CLEAR;
              end
            end
            default: begin
              b2b_start = 1'b1;
              state_d   = ST_CONV;
            end
          endcase
        end
      end

      // Erase from the right so cells at or beyond the cursor stay blank at
      // every intermediate step.
      ST_CLEAR: begin
        if (empty_w) begin
          state_d = ST_IDLE;
        end else begin
          wr_en    = 1'b1;
          wr_idx   = cursor_q - 1'b1;
          cursor_d = cursor_q - 1'b1;
          if (cursor_q == CUR_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_CONV: begin
        if (b2b_done) begin
          // All-or-nothing: reject before any digit is written.
          if (free_cells < CUR_W'(sig_n)) begin
            cmd_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            digits_d = b2b_bcd << (4 * (DIGITS - int'(sig_n)));
            left_d   = sig_n;
            state_d  = ST_EMIT;
          end
        end else if (!b2b_busy) begin
          // Converter not running and no result: never wait forever.
          state_d = ST_IDLE;
        end
      end

      ST_EMIT: begin
        if (full_w || left_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          wr_en    = 1'b1;
          wr_val   = digits_q[4*DIGITS-1 -: 4];
          cursor_d = cursor_q + 1'b1;
          digits_d = {digits_q[4*DIGITS-5:0], SYM_BLANK};
          left_d   = left_q - 1'b1;
          if (left_q == SN_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cursor_q  <= '0;
      cmd_err_q <= 1'b0;
      digits_q  <= '0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      cmd_err_q <= cmd_err_d;
      digits_q  <= digits_d;
      left_q    <= left_d;
    end
  end

  // One register per cell; only a decoded index can be written, so indices
  // at or beyond CELLS are never touched.
  generate
    for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
      always_ff @(posedge clk) begin
        if (rst) begin
          cell_q[gi] <= SYM_BLANK;
        end else if (wr_en && wr_idx == CUR_W'(gi)) begin
          cell_q[gi] <= wr_val;
        end
      end
      assign numbers[4*gi +: 4] = cell_q[gi];
    end
  endgenerate

  assign cursor  = cursor_q;
  assign full    = full_w;
  assign empty   = empty_w;
  assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_calc_text_writer.sv
module tb_calc_text_writer;

  localparam int MAX_INPUT = 384;
  localparam int NUM_W     = 16;
  localparam int DIGITS    = 5;
  localparam int CUR_W     = 7;
  localparam int CELLS     = 96;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [3:0]           cmd_sym;
  logic [NUM_W-1:0]     cmd_num;
  logic [MAX_INPUT-1:0] numbers;
  logic [CUR_W-1:0]     cursor;
  logic                 full;
  logic                 empty;
  logic                 cmd_err;

  always #5 clk = ~clk;

  calc_text_writer #(
    .MAX_INPUT (MAX_INPUT),
    .NUM_W     (NUM_W),
    .DIGITS    (DIGITS),
    .CUR_W     (CUR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sym   (cmd_sym),
    .cmd_num   (cmd_num),
    .numbers   (numbers),
    .cursor    (cursor),
    .full      (full),
    .empty     (empty),
    .cmd_err   (cmd_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of cells and an integer cursor.
  int m_cells [CELLS];
  int m_cur;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  sym;
    logic [15:0] num;
    int          busy;
    int          err;
    int          cur;
    logic [31:0] low32;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MAX_INPUT-1:0] model_vec();
    logic [MAX_INPUT-1:0] v;
    for (int i = 0; i < CELLS; i++) v[4*i +: 4] = 4'(m_cells[i]);
    return v;
  endfunction

  task automatic check_vec(input string name);
    logic [MAX_INPUT-1:0] exp;
    exp = model_vec();
    n_checks++;
    if (numbers !== exp) begin
      n_fail++;
      $display("FAIL %s numbers: got %h expected %h", name, numbers, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CELLS; i++) m_cells[i] = 15;
    m_cur = 0;
  endtask

  // Applies one command to the model; returns expected ready-low cycles and
  // expected cmd_err pulse count.
  task automatic model_apply(input logic [1:0] op, input logic [3:0] sym, input logic [15:0] num,
                             output int exp_busy, output int exp_err);
    int q[$];
    int v;
    exp_busy = 0;
    exp_err  = 0;
    case (op)
      2'b00: begin
        if (m_cur == CELLS) exp_err = 1;
        else begin m_cells[m_cur] = int'(sym); m_cur++; end
      end
      2'b01: begin
        if (m_cur == 0) exp_err = 1;
        else begin m_cur--; m_cells[m_cur] = 15; end
      end
      2'b10: begin
        exp_busy = m_cur;
        while (m_cur > 0) begin m_cur--; m_cells[m_cur] = 15; end
      end
      default: begin
        v = int'(num);
        do begin q.push_front(v % 10); v = v / 10; end while (v > 0);
        if (CELLS - m_cur < q.size()) begin
          exp_err  = 1;
          exp_busy = NUM_W + 1;
        end else begin
          exp_busy = NUM_W + 1 + q.size();
          foreach (q[k]) begin m_cells[m_cur] = q[k]; m_cur++; end
        end
      end
    endcase
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] sym, input logic [15:0] num,
                        output int busy, output int errs);
    int guard;
    busy  = 0;
    errs  = 0;
    guard = 0;
    while (!cmd_ready && guard < 300) begin @(posedge clk); #1; guard++; end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_wait: cmd_ready stuck low, got 0 expected 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sym   = sym;
    cmd_num   = num;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (1) begin
      if (cmd_err) errs++;
      if (cmd_ready) break;
      busy++;
      if (busy > 300) begin
        n_checks++; n_fail++;
        $display("FAIL busy_timeout: ready low %0d cycles, expected at most 300", busy);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_state(input string name);
    check_vec(name);
    check({name, " cursor"}, 64'(cursor), 64'(m_cur));
    check({name, " full"},   64'(full),   64'(m_cur == CELLS));
    check({name, " empty"},  64'(empty),  64'(m_cur == 0));
  endtask

  // Full command with model, busy/err comparison and pulse-width check.
  task automatic run_cmd(input string name, input logic [1:0] op, input logic [3:0] sym,
                         input logic [15:0] num, input bit full_check);
    int eb, ee, b, e;
    model_apply(op, sym, num, eb, ee);
    do_cmd(op, sym, num, b, e);
    if (full_check) begin
      check({name, " busy"}, 64'(b), 64'(eb));
      check({name, " err"},  64'(e), 64'(ee));
      @(posedge clk); #1;
      check({name, " err_pulse"}, 64'(cmd_err), 64'd0);
      check_state(name);
    end
  endtask

  task automatic fill_to(input int target);
    while (m_cur < target) run_cmd("fill", 2'b00, 4'($urandom_range(0, 15)), 16'd0, 1'b0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eb, ee, b, e;
    logic [MAX_INPUT-1:0] ones;
    ones = '1;

    tbl[0]  = '{2'b01, 4'h0, 16'd0,     0,  0, 3, 32'hFFFFF2A1};
    tbl[1]  = '{2'b10, 4'h0, 16'd0,     3,  0, 0, 32'hFFFFFFFF};
    tbl[2]  = '{2'b01, 4'h0, 16'd0,     0,  1, 0, 32'hFFFFFFFF};
    tbl[3]  = '{2'b10, 4'h0, 16'd0,     0,  0, 0, 32'hFFFFFFFF};
    tbl[4]  = '{2'b11, 4'h0, 16'd1234,  21, 0, 4, 32'hFFFF4321};
    tbl[5]  = '{2'b11, 4'h0, 16'd0,     18, 0, 5, 32'hFFF04321};
    tbl[6]  = '{2'b10, 4'h0, 16'd0,     5,  0, 0, 32'hFFFFFFFF};
    tbl[7]  = '{2'b00, 4'hF, 16'd0,     0,  0, 1, 32'hFFFFFFFF};
    tbl[8]  = '{2'b11, 4'h0, 16'd65535, 22, 0, 6, 32'hFF53556F};
    tbl[9]  = '{2'b01, 4'h0, 16'd0,     0,  0, 5, 32'hFFF3556F};
    tbl[10] = '{2'b11, 4'h0, 16'd7,     18, 0, 6, 32'hFF73556F};
    tbl[11] = '{2'b00, 4'hD, 16'd0,     0,  0, 7, 32'hFD73556F};
    tbl[12] = '{2'b10, 4'h0, 16'd0,     7,  0, 0, 32'hFFFFFFFF};

    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_sym   = 4'h0;
    cmd_num   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Reset state over 5 idle cycles.
    for (int i = 0; i < 5; i++) begin
      check("reset cmd_err", 64'(cmd_err), 64'd0);
      check("reset cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
    end
    n_checks++;
    if (numbers !== ones) begin
      n_fail++;
      $display("FAIL reset numbers: got %h expected all ones", numbers);
    end
    check("reset cursor", 64'(cursor), 64'd0);
    check("reset empty",  64'(empty),  64'd1);
    check("reset full",   64'(full),   64'd0);

    // Back-to-back PUTSYM 1, A, 2, E with valid held high.
    begin
      logic [3:0] syms [4];
      syms[0] = 4'h1; syms[1] = 4'hA; syms[2] = 4'h2; syms[3] = 4'hE;
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      for (int i = 0; i < 4; i++) begin
        cmd_sym = syms[i];
        check($sformatf("b2b ready %0d", i), 64'(cmd_ready), 64'd1);
        model_apply(2'b00, syms[i], 16'd0, eb, ee);
        @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      check("b2b ready after", 64'(cmd_ready), 64'd1);
      check("b2b low16", 64'(numbers[15:0]), 64'h0000_0000_0000_E2A1);
      check("b2b upper ones", 64'(&numbers[MAX_INPUT-1:16]), 64'd1);
      check_state("b2b");
    end

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      model_apply(tbl[i].op, tbl[i].sym, tbl[i].num, eb, ee);
      do_cmd(tbl[i].op, tbl[i].sym, tbl[i].num, b, e);
      check({nm, " busy"}, 64'(b), 64'(tbl[i].busy));
      check({nm, " err"},  64'(e), 64'(tbl[i].err));
      @(posedge clk); #1;
      check({nm, " err_pulse"}, 64'(cmd_err), 64'd0);
      check({nm, " cursor"}, 64'(cursor), 64'(tbl[i].cur));
      check({nm, " low32"}, 64'(numbers[31:0]), 64'(tbl[i].low32));
      check_state(nm);
      $display("tbl%0d op=%0d sym=%0h num=%0d busy=%0d err=%0d cursor=%0d", i,
               tbl[i].op, tbl[i].sym, tbl[i].num, b, e, cursor);
    end

    // Fill to 93, oversize PUTNUM is rejected without writing anything.
    fill_to(93);
    check_state("fill93");
    run_cmd("putnum_overflow", 2'b11, 4'h0, 16'd65535, 1'b1);
    check("overflow cursor", 64'(cursor), 64'd93);
    for (int i = 0; i < 3; i++) run_cmd($sformatf("last%0d", i), 2'b00, 4'(i + 3), 16'd0, 1'b1);
    check("full flag", 64'(full), 64'd1);
    run_cmd("putsym_full", 2'b00, 4'h7, 16'd0, 1'b1);
    run_cmd("clear_full", 2'b10, 4'h0, 16'd0, 1'b1);

    // Randomized commands against the model.
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [1:0]  op;
      logic [3:0]  sym;
      logic [15:0] num;
      r   = $urandom_range(0, 19);
      op  = (r < 10) ? 2'b00 : (r < 14) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      sym = 4'($urandom_range(0, 15));
      num = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      run_cmd($sformatf("rnd%0d", i), op, sym, num, 1'b1);
      $display("rnd%0d op=%0d sym=%0h num=%0d cursor=%0d", i, op, sym, num, cursor);
    end

    // Reset during CLEAR: start from cursor 40, reset on the 5th clear cycle.
    apply_reset();
    fill_to(40);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midclear ready", 64'(cmd_ready), 64'd0);
    check("midclear cursor", 64'(cursor), 64'd36);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("clear_rst ready", 64'(cmd_ready), 64'd1);
    check_state("clear_rst");
    $display("reset during CLEAR cursor=%0d", cursor);

    // Reset during EMIT of 12345 from cursor 40.
    fill_to(40);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_num = 16'd12345;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("midemit cursor", 64'(cursor), 64'd42);
    check("midemit cells", 64'(numbers[4*40 +: 8]), 64'h21);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("emit_rst ready", 64'(cmd_ready), 64'd1);
    check_state("emit_rst");
    $display("reset during EMIT cursor=%0d", cursor);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
